ppe_inject_arbiter: RTL

//  Clocked round-robin arbiter sharing one NoC injection port among the NUM_REQ partial-PE packetizers.

---
 rtl/ppe_pkg.sv | 24 ++
 rtl/ppe_rr_grant.sv | 38 +++
 rtl/ppe_inject_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ppe_pkg.sv
// Shared PPE/SPE definitions: packet layout, opcodes, node ids and arbiter states.
package ppe_pkg;

  localparam logic [3:0] OP_WEIGHT    = 4'd0;
  localparam logic [3:0] OP_INPUT_ROW = 4'd1;
  localparam logic [3:0] OP_ROW_REQ   = 4'd2;
  localparam logic [3:0] OP_PSUM      = 4'd3;
  localparam logic [3:0] OP_TS_DONE   = 4'd15;

  localparam logic [3:0] IMEM_ID      = 4'd11;

  typedef struct packed {
    logic [3:0]  dest;
    logic [3:0]  opcode;
    logic [24:0] data;
  } packet_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    BCAST = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ppe_rr_grant.sv
// Rotating-priority one-hot grant: the first requester at or above ptr wins, wrapping.
module ppe_rr_grant #(
  parameter int unsigned N  = 5,
  parameter int unsigned PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any,
  output logic [PW-1:0] idx
);

  logic [PW:0] cand_s;

  // Scan N candidates starting at ptr; the first valid one takes the grant.
  always_comb begin
    grant  = {N{1'b0}};
    any    = 1'b0;
    idx    = {PW{1'b0}};
    cand_s = {(PW+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      cand_s = {1'b0, ptr} + (PW+1)'(i);
      if (cand_s >= (PW+1)'(N)) begin
        cand_s = cand_s - (PW+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!any && req[cand_s[PW-1:0]]) begin
        grant[cand_s[PW-1:0]] = 1'b1;
        idx                   = cand_s[PW-1:0];
        any                   = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/ppe_inject_arbiter.sv
// Round-robin arbiter sharing one NoC injection port among the PPE packetizers;
// counts partial sums per PPE and broadcasts timestep-done when every PPE is full.
module ppe_inject_arbiter
  import ppe_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 5,
  parameter int unsigned FIRST_PE_ID = 5,
  parameter int unsigned PKT_W       = 33,
  parameter int unsigned OUTPUT_DIM  = 21,
  parameter int unsigned NUM_TS      = 2,
  parameter int unsigned OP_TS_DONE  = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*PKT_W-1:0]     req_pkt,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  output logic [PKT_W-1:0]             out_pkt,
  input  logic                         out_ready,
  output logic [$clog2(NUM_TS+1)-1:0]  ts_idx,
  output logic                         all_done,
  output logic                         err
);

  localparam int unsigned FULL = OUTPUT_DIM * OUTPUT_DIM;
  localparam int unsigned CW   = $clog2(FULL + 1);
  localparam int unsigned PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW   = $clog2(NUM_TS + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FULL);
  localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);
  localparam logic [TW-1:0] LAST_TS  = TW'(NUM_TS - 1);

  state_t               state_r, state_s;
  logic [PW-1:0]        ptr_r, win_s, bcast_idx_r;
  logic [NUM_REQ-1:0]   grant_s;
  logic                 any_s;
  logic [CW-1:0]        cnt_r [NUM_REQ];
  logic                 out_valid_r;
  logic [PKT_W-1:0]     out_pkt_r, win_pkt_s, bcast_pkt_s;
  logic [TW-1:0]        ts_r;
  logic                 all_done_r, err_r;
  logic                 can_load_s, xfer_s, all_full_s, win_psum_s;
  logic                 bcast_load_s, bcast_last_s;

  ppe_rr_grant #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (grant_s),
    .any   (any_s),
    .idx   (win_s)
  );

  assign can_load_s  = !out_valid_r || out_ready;
  assign req_ready   = (state_r == ARB && can_load_s) ? grant_s : {NUM_REQ{1'b0}};
  assign xfer_s      = (state_r == ARB) && can_load_s && any_s;
  assign win_psum_s  = win_pkt_s[PKT_W-1 -: 4] < 4'(NUM_REQ);
  assign bcast_pkt_s = {4'(FIRST_PE_ID) + 4'(bcast_idx_r), 4'(OP_TS_DONE), {(PKT_W-8){1'b0}}};

  assign out_valid = out_valid_r;
  assign out_pkt   = out_pkt_r;
  assign ts_idx    = ts_r;
  assign all_done  = all_done_r;
  assign err       = err_r;

  // Select the winning requester's packet slice.
  always_comb begin
    win_pkt_s = {PKT_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (PW'(k) == win_s) begin
        win_pkt_s = req_pkt[k*PKT_W +: PKT_W];
      end else begin
        win_pkt_s = win_pkt_s;
      end
    end
  end

  // Every PPE has reached its full partial-sum count for this timestep.
  always_comb begin
    all_full_s = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cnt_r[k] != FULL_CNT) begin
        all_full_s = 1'b0;
      end else begin
        all_full_s = all_full_s;
      end
    end
  end

  // Next-state logic and broadcast load strobes.
  always_comb begin
    state_s      = state_r;
    bcast_load_s = 1'b0;
    bcast_last_s = 1'b0;
    case (state_r)
      ARB: begin
        if (all_full_s) begin
          state_s = BCAST;
        end else begin
          state_s = ARB;
        end
      end
      BCAST: begin
        if (can_load_s) begin
          bcast_load_s = 1'b1;
          if (bcast_idx_r == LAST_REQ) begin
            bcast_last_s = 1'b1;
            state_s      = (ts_r == LAST_TS) ? DONE : ARB;
          end else begin
            state_s = BCAST;
          end
        end else begin
          state_s = BCAST;
        end
      end
      DONE:    state_s = DONE;
      default: state_s = ARB;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB;
    end else begin
      state_r <= state_s;
    end
  end

  // Output register: loads a broadcast or a granted packet, otherwise drains or holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_pkt_r   <= {PKT_W{1'b0}};
    end else if (bcast_load_s) begin
      out_valid_r <= 1'b1;
      out_pkt_r   <= bcast_pkt_s;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_pkt_r   <= win_pkt_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Round-robin pointer: advances past the winner, restarts at 0 each timestep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {PW{1'b0}};
    end else if (bcast_last_s) begin
      ptr_r <= {PW{1'b0}};
    end else if (xfer_s) begin
      ptr_r <= (win_s == LAST_REQ) ? {PW{1'b0}} : win_s + PW'(1);
    end
  end

  // Per-PPE partial-sum counters; an extra sum at full count saturates and flags err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) cnt_r[k] <= {CW{1'b0}};
      err_r <= 1'b0;
    end else if (bcast_last_s) begin
      for (int k = 0; k < NUM_REQ; k++) cnt_r[k] <= {CW{1'b0}};
    end else if (xfer_s && win_psum_s) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (PW'(k) == win_s) begin
          if (cnt_r[k] == FULL_CNT) begin
            err_r <= 1'b1;
          end else begin
            cnt_r[k] <= cnt_r[k] + CW'(1);
          end
        end
      end
    end
  end

  // Broadcast index, timestep index and completion flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcast_idx_r <= {PW{1'b0}};
      ts_r        <= {TW{1'b0}};
      all_done_r  <= 1'b0;
    end else begin
      if (bcast_load_s) begin
        bcast_idx_r <= bcast_last_s ? {PW{1'b0}} : bcast_idx_r + PW'(1);
      end
      if (bcast_last_s) begin
        ts_r <= ts_r + TW'(1);
      end
      all_done_r <= (state_s == DONE);
    end
  end

endmodule
